pu_div_sched: RTL and testbench

- Scheduler that shares one pipelined integer divider (fixed latency, no stall input) between N_REQ requesters.
- Round-robin arbitration accepts at most one operation per clock and drives the divider operands.
- Each in-flight operation carries a tag (requester id, invalid flag) down a shift pipe matched to the divider latency.
- Each result is returned on a shared response bus with the requester id and an invalid flag.

---
 rtl/pu_div_sched_pkg.sv | 20 ++
 rtl/pu_div_sched_rr_arbiter.sv | 30 +++
 rtl/pu_div_sched.sv | 134 +++++++++++++
 tb/tb_pu_div_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_div_sched_pkg.sv
// Shared definitions for the divider scheduler: defaults, tag layout, helpers.
package pu_div_sched_pkg;

  // Default sizing; DEF_DIV_LATENCY must track the divider pipeline depth.
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_ID_WIDTH    = 2;
  localparam int DEF_DIV_LATENCY = 8;
  localparam int DEF_CNT_WIDTH   = 4;

  // Tag layout: {id, inv, valid}
  localparam int TAG_VALID  = 0;
  localparam int TAG_INV    = 1;
  localparam int TAG_ID_LSB = 2;

  function automatic int tag_width(input int id_width);
    return TAG_ID_LSB + id_width;
  endfunction

endpackage

// File: rtl/pu_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  // Walk the N positions starting at ptr; the first hit wins.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/pu_div_sched.sv
// Shares one fixed-latency pipelined divider among N_REQ requesters.
// Operands are registered toward the divider; a tag pipe carries owner id and
// invalid flag alongside, and the result is re-registered onto the response bus.
module pu_div_sched
  import pu_div_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int N_REQ       = DEF_N_REQ,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_numer,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_denom,
  input  logic [N_REQ-1:0]            req_attr_inv,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       div_numer,
  output logic [DATA_WIDTH-1:0]       div_denom,
  input  logic [DATA_WIDTH-1:0]       div_quotient,
  input  logic [DATA_WIDTH-1:0]       div_remain,
  output logic                        rsp_valid,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic [DATA_WIDTH-1:0]       rsp_quotient,
  output logic [DATA_WIDTH-1:0]       rsp_remain,
  output logic                        rsp_invalid,
  output logic [CNT_WIDTH-1:0]        inflight
);

  localparam int TAG_W = tag_width(ID_WIDTH);
  // Stage 0 sits beside the registered operands, so DIV_LATENCY more stages
  // bring the tag level with the divider output.
  localparam int STAGES = DIV_LATENCY;

  logic [N_REQ-1:0]             grant;
  logic [ID_WIDTH-1:0]          gidx;
  logic [ID_WIDTH-1:0]          ptr_q, ptr_d;
  logic                         hs;
  logic [DATA_WIDTH-1:0]        sel_numer, sel_denom;
  logic [TAG_W-1:0]             tag_new;
  logic [STAGES:0][TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]             tag_last;
  logic [DATA_WIDTH-1:0]        div_numer_q, div_denom_q;
  logic                         rsp_valid_q, rsp_invalid_q;
  logic [ID_WIDTH-1:0]          rsp_id_q;
  logic [DATA_WIDTH-1:0]        rsp_quotient_q, rsp_remain_q;
  logic [CNT_WIDTH-1:0]         inflight_q, inflight_d;

  rr_arbiter #(.N(N_REQ), .IDW(ID_WIDTH)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign req_ready = rst ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign sel_numer = req_numer[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_denom = req_denom[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign tag_last  = tag_q[STAGES];

  // New tag and next pointer for the granted requester.
  always_comb begin
    tag_new = '0;
    ptr_d   = ptr_q;
    if (hs) begin
      tag_new[TAG_VALID]                = 1'b1;
      tag_new[TAG_INV]                  = req_attr_inv[gidx] | (sel_denom == '0);
      tag_new[TAG_ID_LSB +: ID_WIDTH]   = gidx;
      ptr_d = (int'(gidx) == N_REQ - 1) ? '0 : gidx + ID_WIDTH'(1);
    end
  end

  // In-flight count: issue increments, response strobe decrements.
  always_comb begin
    inflight_d = inflight_q;
    case ({hs, rsp_valid_q})
      2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Pointer, operand registers, tag pipe and in-flight counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= '0;
      div_numer_q <= '0;
      div_denom_q <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      if (hs) begin
        div_numer_q <= sel_numer;
        div_denom_q <= sel_denom;
      end
      tag_q[0] <= tag_new;
      for (int s = 1; s <= STAGES; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Response register: pair divider output with the last tag; zero when idle
  // or invalid so stale divider data never leaks onto the bus.
  always_ff @(posedge clk) begin
    if (!rst || !tag_last[TAG_VALID]) begin
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_invalid_q  <= 1'b0;
      rsp_quotient_q <= '0;
      rsp_remain_q   <= '0;
    end else begin
      rsp_valid_q    <= 1'b1;
      rsp_id_q       <= tag_last[TAG_ID_LSB +: ID_WIDTH];
      rsp_invalid_q  <= tag_last[TAG_INV];
      rsp_quotient_q <= tag_last[TAG_INV] ? '0 : div_quotient;
      rsp_remain_q   <= tag_last[TAG_INV] ? '0 : div_remain;
    end
  end

  assign div_numer    = div_numer_q;
  assign div_denom    = div_denom_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_invalid  = rsp_invalid_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_remain   = rsp_remain_q;
  assign inflight     = inflight_q;

endmodule

// File: tb/tb_pu_div_sched.sv
// Bench for pu_div_sched: behavioural 8-stage divider, scoreboard queue of
// expected responses with due cycles, round-robin pointer model.
module tb_pu_div_sched;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int LAT = 8;
  localparam int RSP_DELAY = LAT + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_numer, req_denom;
  logic [NR-1:0]   req_attr_inv;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   div_numer, div_denom, div_quotient, div_remain;
  logic            rsp_valid, rsp_invalid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_quotient, rsp_remain;
  logic [3:0]      inflight;

  always #5 clk = ~clk;

  pu_div_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_numer(req_numer),
    .req_denom(req_denom), .req_attr_inv(req_attr_inv), .req_ready(req_ready),
    .div_numer(div_numer), .div_denom(div_denom), .div_quotient(div_quotient),
    .div_remain(div_remain), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remain(rsp_remain),
    .rsp_invalid(rsp_invalid), .inflight(inflight)
  );

  // Divider model: operands seen in cycle c produce results in cycle c+LAT-1+1.
  logic [DW-1:0] pq [LAT];
  logic [DW-1:0] pr [LAT];
  always @(posedge clk) begin
    pq[0] <= (div_denom == '0) ? 32'hDEADBEEF : div_numer / div_denom;
    pr[0] <= (div_denom == '0) ? 32'hBADC0DE0 : div_numer % div_denom;
    for (int k = 1; k < LAT; k++) begin
      pq[k] <= pq[k-1];
      pr[k] <= pr[k-1];
    end
  end
  assign div_quotient = pq[LAT-1];
  assign div_remain   = pr[LAT-1];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] q;
    logic [31:0] r;
    logic        inv;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mptr = 0;
  int          peak = 0;
  logic [31:0] opn [NR];
  logic [31:0] opd [NR];

  // Advance one cycle, then check the response bus and counter for the new cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      sb.delete();
      mptr = 0;
    end
    if (int'(inflight) > peak) peak = int'(inflight);
    checks++;
    if (inflight !== 4'(sb.size()))
      begin errs++; $display("FAIL inflight cyc=%0d got=%0d want=%0d", cyc, inflight, sb.size()); end
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errs++; $display("FAIL unexpected_rsp cyc=%0d id=%0d", cyc, rsp_id);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_quotient !== e.q || rsp_remain !== e.r ||
            rsp_invalid !== e.inv || cyc != e.due) begin
          errs++;
          $display("FAIL rsp cyc=%0d got id=%0d q=%h r=%h inv=%b want id=%0d q=%h r=%h inv=%b due=%0d",
                   cyc, rsp_id, rsp_quotient, rsp_remain, rsp_invalid, e.id, e.q, e.r, e.inv, e.due);
        end
      end
    end else begin
      checks++;
      if ({rsp_id, rsp_quotient, rsp_remain, rsp_invalid} !== '0 || rsp_valid !== 1'b0) begin
        errs++; $display("FAIL idle_bus cyc=%0d valid=%b id=%0d q=%h r=%h inv=%b",
                         cyc, rsp_valid, rsp_id, rsp_quotient, rsp_remain, rsp_invalid);
      end
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        checks++; errs++;
        $display("FAIL missing_rsp cyc=%0d want id=%0d due=%0d", cyc, sb[0].id, sb[0].due);
        void'(sb.pop_front());
      end
    end
  endtask

  // Drive one cycle of requests, check the grant, record the expected result.
  task automatic issue(input logic [3:0] v, input logic [3:0] inv, output int gi);
    logic [3:0] g;
    logic [1:0] idx;
    exp_t e;
    req_valid    = v;
    req_attr_inv = inv;
    for (int i = 0; i < NR; i++) begin
      req_numer[i*DW +: DW] = opn[i];
      req_denom[i*DW +: DW] = opd[i];
    end
    #1;
    gi = -1;
    g  = '0;
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        idx = 2'((mptr + k) % NR);
        if (gi < 0 && v[idx]) begin gi = int'(idx); g[idx] = 1'b1; end
      end
    end
    checks++;
    if (req_ready !== g)
      begin errs++; $display("FAIL grant cyc=%0d got=%b want=%b", cyc, req_ready, g); end
    if (gi >= 0) begin
      e.id  = 2'(gi);
      e.inv = inv[gi] | (opd[gi] == 0);
      e.q   = e.inv ? 32'h0 : opn[gi] / opd[gi];
      e.r   = e.inv ? 32'h0 : opn[gi] % opd[gi];
      e.due = cyc + RSP_DELAY;
      sb.push_back(e);
      mptr = (gi + 1) % NR;
    end
    tick();
  endtask

  task automatic idle(input int n);
    int gi;
    for (int i = 0; i < n; i++) issue(4'b0, 4'b0, gi);
  endtask

  task automatic test_reset();
    int gi;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin opn[i] = 32'(i + 1); opd[i] = 32'd1; end
    issue(4'hF, 4'h0, gi);
    issue(4'hF, 4'h0, gi);
    checks++;
    if (div_numer !== '0 || div_denom !== '0)
      begin errs++; $display("FAIL reset_operands got n=%h d=%h want 0", div_numer, div_denom); end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_single();
    int gi, t0;
    opn[2] = 32'd100; opd[2] = 32'd7;
    t0 = cyc;
    issue(4'b0100, 4'b0, gi);
    checks++;
    if (gi != 2 || div_numer !== 32'd100 || div_denom !== 32'd7)
      begin errs++; $display("FAIL single_issue gi=%0d n=%0d d=%0d want 2/100/7", gi, div_numer, div_denom); end
    idle(RSP_DELAY + 2);
    checks++;
    if (sb.size() != 0 || inflight !== 4'd0)
      begin errs++; $display("FAIL single_drain left=%0d inflight=%0d want 0", sb.size(), inflight); end
    if (t0 < 0) $display("unreachable");
  endtask

  task automatic test_all_valid();
    int gi, want;
    for (int i = 0; i < NR; i++) begin opn[i] = 32'(1000 + 37*i); opd[i] = 32'(3 + i); end
    peak = 0;
    want = mptr;
    for (int n = 0; n < 8; n++) begin
      issue(4'hF, 4'h0, gi);
      checks++;
      if (gi != want) begin errs++; $display("FAIL rr_order n=%0d got=%0d want=%0d", n, gi, want); end
      want = (want + 1) % NR;
    end
    idle(RSP_DELAY + 2);
    checks++;
    if (peak != 8) begin errs++; $display("FAIL inflight_peak got=%0d want=8", peak); end
  endtask

  task automatic test_invalid();
    int gi;
    opn[1] = 32'd5; opd[1] = 32'd0;
    opn[3] = 32'd9; opd[3] = 32'd3;
    issue(4'b0010, 4'b0000, gi);
    issue(4'b1000, 4'b1000, gi);
    idle(RSP_DELAY + 2);
  endtask

  task automatic test_pointer();
    int gi;
    for (int i = 0; i < NR; i++) begin opn[i] = 32'(50 + i); opd[i] = 32'd4; end
    mptr = mptr;
    issue(4'b0100, 4'b0, gi);       // pointer now 3
    issue(4'b0010, 4'b0, gi);       // wraps to 1, pointer 2
    checks++;
    if (gi != 1) begin errs++; $display("FAIL ptr_wrap got=%0d want=1", gi); end
    issue(4'b1001, 4'b0, gi);       // from 2: 3 before 0
    checks++;
    if (gi != 3) begin errs++; $display("FAIL ptr_skip got=%0d want=3", gi); end
    idle(RSP_DELAY + 2);
  endtask

  task automatic test_reset_mid();
    int gi;
    for (int i = 0; i < NR; i++) begin opn[i] = 32'(77 + i); opd[i] = 32'd5; end
    issue(4'b0001, 4'b0, gi);
    issue(4'b0010, 4'b0, gi);
    issue(4'b0100, 4'b0, gi);
    idle(1);
    rst = 1'b0;
    issue(4'hF, 4'h0, gi);          // grant suppressed; reset takes effect at this edge
    rst = 1'b1;
    idle(12);
    opn[0] = 32'd81; opd[0] = 32'd9;
    issue(4'b0001, 4'b0, gi);
    checks++;
    if (gi != 0) begin errs++; $display("FAIL post_reset_grant got=%0d want=0", gi); end
    idle(RSP_DELAY + 2);
  endtask

  task automatic test_back_to_back();
    int gi;
    opn[0] = 32'hFFFFFFFF; opd[0] = 32'd1;
    opn[1] = 32'h0;        opd[1] = 32'hFFFFFFFF;
    issue(4'b0001, 4'b0, gi);
    issue(4'b0010, 4'b0, gi);
    idle(RSP_DELAY + 2);
    checks++;
    if (sb.size() != 0) begin errs++; $display("FAIL final_drain left=%0d want=0", sb.size()); end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_attr_inv = '0; req_numer = '0; req_denom = '0;
    for (int i = 0; i < NR; i++) begin opn[i] = '0; opd[i] = 32'd1; end
    test_reset();
    test_single();
    test_all_valid();
    test_invalid();
    test_pointer();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
